// File: rtl/qf_sts_rdclr_if.sv
// rtl/qf_sts_rdclr_if.sv - read-and-clear handshake and mask register bundle
interface qf_sts_rdclr_if #(
   parameter int PAR_BIT_WIDTH = 10,
   parameter int PAR_CNT_WIDTH = 8
);
   logic                     rd_req;
   logic                     rd_ack;
   logic [PAR_BIT_WIDTH-1:0] rd_data;
   logic [PAR_CNT_WIDTH-1:0] rd_cnt;
   logic [PAR_BIT_WIDTH-1:0] rd_ovf;
   logic                     mask_wr_en;
   logic [PAR_BIT_WIDTH-1:0] mask_wrdata;
   logic [PAR_BIT_WIDTH-1:0] mask;

   modport master (
      output rd_req, mask_wr_en, mask_wrdata,
      input  rd_ack, rd_data, rd_cnt, rd_ovf, mask
   );

   modport slave (
      input  rd_req, mask_wr_en, mask_wrdata,
      output rd_ack, rd_data, rd_cnt, rd_ovf, mask
   );
endinterface

// File: rtl/qf_sts_rdclr.sv
// rtl/qf_sts_rdclr.sv - sticky event status with atomic read-and-clear snapshot and masked irq
// Optional overflow tracking enabled by defining QF_STS_OVF_EN.
module qf_sts_rdclr #(
   parameter int                     PAR_BIT_WIDTH    = 10,
   parameter int                     PAR_CNT_WIDTH    = 8,
   parameter logic [PAR_BIT_WIDTH-1:0] PAR_MASK_DEFAULT = '0
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic [PAR_BIT_WIDTH-1:0] evt_in,
   output logic                     irq,
   qf_sts_rdclr_if.slave            bus
);
   typedef enum logic {ST_IDLE, ST_ACK} state_t;

   localparam logic [PAR_CNT_WIDTH-1:0] CNT_ONE = PAR_CNT_WIDTH'(1);

   state_t                   state_q, state_d;
   logic [PAR_BIT_WIDTH-1:0] sticky_q, sticky_d;
   logic [PAR_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [PAR_BIT_WIDTH-1:0] mask_q, mask_d;
   logic                     irq_q, irq_d;
   logic [PAR_BIT_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [PAR_CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic [PAR_BIT_WIDTH-1:0] sticky_acc;
   logic [PAR_CNT_WIDTH-1:0] cnt_acc;
   logic                     snap;

   always_comb begin
      sticky_acc = sticky_q | evt_in;
      cnt_acc    = cnt_q;
      if (|evt_in && cnt_q != '1) begin
         cnt_acc = cnt_q + CNT_ONE;
      end
      mask_d    = bus.mask_wr_en ? bus.mask_wrdata : mask_q;
      state_d   = state_q;
      sticky_d  = sticky_acc;
      cnt_d     = cnt_acc;
      rd_data_d = rd_data_q;
      rd_cnt_d  = rd_cnt_q;
      snap      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // The snapshot includes this cycle's events, which are then not kept
            if (bus.rd_req) begin
               snap      = 1'b1;
               state_d   = ST_ACK;
               rd_data_d = sticky_acc;
               rd_cnt_d  = cnt_acc;
               sticky_d  = '0;
               cnt_d     = '0;
            end
         end
         ST_ACK: begin
            if (!bus.rd_req) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      irq_d = |(sticky_d & mask_d);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         sticky_q  <= '0;
         cnt_q     <= '0;
         mask_q    <= PAR_MASK_DEFAULT;
         irq_q     <= 1'b0;
         rd_data_q <= '0;
         rd_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         sticky_q  <= sticky_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         irq_q     <= irq_d;
         rd_data_q <= rd_data_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

`ifdef QF_STS_OVF_EN
   logic [PAR_BIT_WIDTH-1:0] ovf_q, ovf_d;
   logic [PAR_BIT_WIDTH-1:0] rd_ovf_q, rd_ovf_d;
   logic [PAR_BIT_WIDTH-1:0] ovf_acc;

   // A bit overflows when an event lands on a bit that is already sticky
   always_comb begin
      ovf_acc  = ovf_q | (evt_in & sticky_q);
      ovf_d    = snap ? '0 : ovf_acc;
      rd_ovf_d = snap ? ovf_acc : rd_ovf_q;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ovf_q    <= '0;
         rd_ovf_q <= '0;
      end else begin
         ovf_q    <= ovf_d;
         rd_ovf_q <= rd_ovf_d;
      end
   end

   assign bus.rd_ovf = rd_ovf_q;
`else
   assign bus.rd_ovf = '0;
`endif

   assign bus.rd_ack  = (state_q == ST_ACK);
   assign bus.rd_data = rd_data_q;
   assign bus.rd_cnt  = rd_cnt_q;
   assign bus.mask    = mask_q;
   assign irq         = irq_q;
endmodule

// File: tb/tb_qf_sts_rdclr.sv
// tb/tb_qf_sts_rdclr.sv - directed self-checking bench for qf_sts_rdclr
module tb_qf_sts_rdclr;
   logic       sys_clk;
   logic       sys_rst_n;
   logic [9:0] evt_in;
   logic       irq;
   int         total;
   int         bad;
   logic [9:0] exp_ovf;

   qf_sts_rdclr_if #(.PAR_BIT_WIDTH(10), .PAR_CNT_WIDTH(8)) bus ();

   qf_sts_rdclr #(
      .PAR_BIT_WIDTH   (10),
      .PAR_CNT_WIDTH   (8),
      .PAR_MASK_DEFAULT(10'h005)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .evt_in   (evt_in),
      .irq      (irq),
      .bus      (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      sys_rst_n       = 1'b0;
      evt_in          = '0;
      bus.rd_req      = 1'b1;
      bus.mask_wr_en  = 1'b0;
      bus.mask_wrdata = '0;
      tick();
      tick();
      check("rst_mask", 32'(bus.mask), 32'h005);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_ack", 32'(bus.rd_ack), 32'h0);
      check("rst_data", 32'(bus.rd_data), 32'h0);
      check("rst_cnt", 32'(bus.rd_cnt), 32'h0);
      check("rst_ovf", 32'(bus.rd_ovf), 32'h0);

      sys_rst_n = 1'b1;
      tick();
      check("post_rst_req_ack", 32'(bus.rd_ack), 32'h1);
      check("post_rst_req_data", 32'(bus.rd_data), 32'h0);
      bus.rd_req = 1'b0;
      tick();
      check("post_rst_ack_fall", 32'(bus.rd_ack), 32'h0);

      evt_in = 10'h003;
      tick();
      check("basic_irq_latency", 32'(irq), 32'h1);
      evt_in = 10'h010;
      tick();
      evt_in = 10'h000;
      tick();
      check("basic_no_ack_yet", 32'(bus.rd_ack), 32'h0);
      bus.rd_req = 1'b1;
      tick();
      check("basic_ack", 32'(bus.rd_ack), 32'h1);
      check("basic_data", 32'(bus.rd_data), 32'h013);
      check("basic_cnt", 32'(bus.rd_cnt), 32'h2);
      check("basic_irq_clear", 32'(irq), 32'h0);
      tick();
      check("basic_ack_hold", 32'(bus.rd_ack), 32'h1);
      bus.rd_req = 1'b0;
      tick();
      check("basic_ack_drop", 32'(bus.rd_ack), 32'h0);
      check("basic_data_hold", 32'(bus.rd_data), 32'h013);
      bus.rd_req = 1'b1;
      tick();
      check("reread_data", 32'(bus.rd_data), 32'h0);
      check("reread_cnt", 32'(bus.rd_cnt), 32'h0);
      bus.rd_req = 1'b0;
      tick();

      bus.rd_req = 1'b1;
      evt_in     = 10'h200;
      tick();
      evt_in = 10'h000;
      check("snapedge_data", 32'(bus.rd_data), 32'h200);
      check("snapedge_cnt", 32'(bus.rd_cnt), 32'h1);
      tick();
      bus.rd_req = 1'b0;
      tick();
      bus.rd_req = 1'b1;
      tick();
      check("snapedge_next_data", 32'(bus.rd_data), 32'h000);
      bus.rd_req = 1'b0;
      tick();

      bus.mask_wr_en  = 1'b1;
      bus.mask_wrdata = 10'h002;
      evt_in          = 10'h001;
      tick();
      bus.mask_wr_en = 1'b0;
      evt_in         = 10'h000;
      check("mask_value", 32'(bus.mask), 32'h002);
      check("mask_same_cycle_irq", 32'(irq), 32'h0);
      tick();
      check("mask_irq_low", 32'(irq), 32'h0);
      evt_in = 10'h002;
      tick();
      evt_in = 10'h000;
      check("mask_irq_high", 32'(irq), 32'h1);
      tick();
      check("mask_irq_sticky", 32'(irq), 32'h1);
      bus.rd_req = 1'b1;
      tick();
      check("mask_irq_cleared", 32'(irq), 32'h0);
      check("mask_data", 32'(bus.rd_data), 32'h003);
      check("mask_cnt", 32'(bus.rd_cnt), 32'h2);
      bus.rd_req = 1'b0;
      tick();

      evt_in = 10'h001;
      for (int i = 0; i < 300; i++) begin
         tick();
      end
      evt_in     = 10'h000;
      bus.rd_req = 1'b1;
      tick();
      check("sat_cnt", 32'(bus.rd_cnt), 32'hff);
      check("sat_data", 32'(bus.rd_data), 32'h001);
      bus.rd_req = 1'b0;
      tick();

`ifdef QF_STS_OVF_EN
      exp_ovf = 10'h004;
`else
      exp_ovf = 10'h000;
`endif
      evt_in = 10'h004;
      tick();
      evt_in = 10'h000;
      tick();
      evt_in = 10'h004;
      tick();
      evt_in = 10'h000;
      tick();
      bus.rd_req = 1'b1;
      tick();
      check("ovf_flags", 32'(bus.rd_ovf), 32'(exp_ovf));
      check("ovf_data", 32'(bus.rd_data), 32'h004);
      check("ovf_cnt", 32'(bus.rd_cnt), 32'h2);
      check("ovf_in_ack", 32'(bus.rd_ack), 32'h1);

      sys_rst_n = 1'b0;
      #1;
      check("midrst_ack", 32'(bus.rd_ack), 32'h0);
      check("midrst_data", 32'(bus.rd_data), 32'h0);
      check("midrst_cnt", 32'(bus.rd_cnt), 32'h0);
      check("midrst_ovf", 32'(bus.rd_ovf), 32'h0);
      check("midrst_mask", 32'(bus.mask), 32'h005);
      bus.rd_req = 1'b0;
      tick();
      sys_rst_n = 1'b1;
      tick();
      check("midrst_idle_after", 32'(bus.rd_ack), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
